// File: rtl/fifo_credit_tx.sv
// Credit-based transmit side feeding a remote push/pop FIFO of DEPTH entries.
// Optional stall statistics counter enabled by defining FIFO_CREDIT_TX_STATS_EN.
module fifo_credit_tx #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ALM_FULL_TH  = 1,
  parameter int unsigned ALM_EMPTY_TH = 1,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  dtype             data_i,
  output logic             push_o,
  output dtype             data_o,
  input  logic             credit_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             alm_full_o,
  output logic             alm_empty_o,
  output logic [CNT_W-1:0] credits_o,
  output logic             err_o,
  output logic [31:0]      stall_cnt_o
);

  localparam logic [CNT_W-1:0] CredMax    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AlmFullTh  = CNT_W'(ALM_FULL_TH);
  localparam logic [CNT_W-1:0] AlmEmptyTh = CNT_W'(ALM_EMPTY_TH);

`ifndef COMMON_CELLS_ASSERTS_OFF
  if (DEPTH < 1) begin : g_depth_chk
    $error("fifo_credit_tx: DEPTH must be >= 1");
  end
  if (ALM_FULL_TH > DEPTH) begin : g_af_chk
    $error("fifo_credit_tx: ALM_FULL_TH must be <= DEPTH");
  end
  if (ALM_EMPTY_TH > DEPTH) begin : g_ae_chk
    $error("fifo_credit_tx: ALM_EMPTY_TH must be <= DEPTH");
  end
`endif

  logic [CNT_W-1:0] credits_q, credits_d;
  logic             push_q, push_d;
  dtype             data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] in_flight;
  logic             accept;

  // Ready comes from registered credits only; a returning credit opens ready one cycle later.
  assign ready_o = (credits_q != '0) && !flush_i && !rst_i;
  assign accept  = valid_i && ready_o;

  always_comb begin
    credits_d = credits_q;
    push_d    = accept;
    data_d    = accept ? data_i : data_q;
    err_d     = err_q;
    if (flush_i) begin
      credits_d = CredMax;
    end else if (accept && !credit_i) begin
      credits_d = credits_q - CNT_W'(1);
    end else if (!accept && credit_i) begin
      if (credits_q < CredMax) begin
        credits_d = credits_q + CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credits_q <= CredMax;
      push_q    <= 1'b0;
      data_q    <= dtype'('0);
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      push_q    <= push_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  assign in_flight   = CredMax - credits_q;
  assign push_o      = push_q;
  assign data_o      = data_q;
  assign err_o       = err_q;
  assign credits_o   = credits_q;
  assign full_o      = (credits_q == '0);
  assign empty_o     = (credits_q == CredMax);
  assign alm_full_o  = (in_flight >= AlmFullTh);
  assign alm_empty_o = (in_flight <= AlmEmptyTh);

`ifdef FIFO_CREDIT_TX_STATS_EN
  logic [31:0] stall_q, stall_d;

  // Counts cycles where upstream is blocked purely by lack of credit.
  always_comb begin
    stall_d = stall_q;
    if (valid_i && (credits_q == '0) && !flush_i && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fifo_credit_tx.sv
// Directed table-driven bench for fifo_credit_tx with DEPTH=4.
module tb_fifo_credit_tx;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AF_TH = 3;
  localparam int unsigned AE_TH = 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, flush, valid, credit;
  logic [DW-1:0] din;
  logic          ready, push, full, empty, alm_full, alm_empty, err;
  logic [DW-1:0] dout;
  logic [CW-1:0] credits;
  logic [31:0]   stall_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fifo_credit_tx #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .ALM_FULL_TH (AF_TH),
    .ALM_EMPTY_TH(AE_TH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .valid_i    (valid),
    .ready_o    (ready),
    .data_i     (din),
    .push_o     (push),
    .data_o     (dout),
    .credit_i   (credit),
    .full_o     (full),
    .empty_o    (empty),
    .alm_full_o (alm_full),
    .alm_empty_o(alm_empty),
    .credits_o  (credits),
    .err_o      (err),
    .stall_cnt_o(stall_cnt)
  );

  typedef struct {
    logic          rst;
    logic          flush;
    logic          valid;
    logic          credit;
    logic [DW-1:0] data;
    logic          ready;
    logic          push;
    logic [DW-1:0] dout;
    int            cr;
    logic          err;
    int            stall;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic f, logic v, logic c, logic [DW-1:0] d,
                              logic rdy, logic p, logic [DW-1:0] q, int cr, logic e, int st);
    vec_t x;
    x.rst = r; x.flush = f; x.valid = v; x.credit = c; x.data = d;
    x.ready = rdy; x.push = p; x.dout = q; x.cr = cr; x.err = e; x.stall = st;
    return x;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check combinational ready, then registered state after the edge.
  task automatic apply(vec_t v, string tag);
    int st;
    rst = v.rst; flush = v.flush; valid = v.valid; credit = v.credit; din = v.data;
    #1;
    chk({tag, " ready"}, int'(ready), int'(v.ready));
    @(posedge clk);
    #1;
`ifdef FIFO_CREDIT_TX_STATS_EN
    st = v.stall;
`else
    st = 0;
`endif
    chk({tag, " push"},      int'(push),      int'(v.push));
    chk({tag, " data"},      int'(dout),      int'(v.dout));
    chk({tag, " credits"},   int'(credits),   v.cr);
    chk({tag, " full"},      int'(full),      int'(v.cr == 0));
    chk({tag, " empty"},     int'(empty),     int'(v.cr == DEPTH));
    chk({tag, " alm_full"},  int'(alm_full),  int'((DEPTH - v.cr) >= AF_TH));
    chk({tag, " alm_empty"}, int'(alm_empty), int'((DEPTH - v.cr) <= AE_TH));
    chk({tag, " err"},       int'(err),       int'(v.err));
    chk({tag, " stall"},     int'(stall_cnt), st);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; valid = 1'b0; credit = 1'b0; din = '0;
    @(posedge clk);
    #1;

    //          rst f  v  c  data   rdy push dout  cr err stall
    vt.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 4, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 8'hA1, 1, 1, 8'hA1, 3, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 8'hA2, 1, 1, 8'hA2, 2, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 8'hA3, 1, 1, 8'hA3, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 8'hA4, 1, 1, 8'hA4, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 8'hA5, 0, 0, 8'hA4, 0, 0, 1));
    vt.push_back(mk(0, 0, 1, 1, 8'hA6, 0, 0, 8'hA4, 1, 0, 2));
    vt.push_back(mk(0, 0, 1, 0, 8'hA7, 1, 1, 8'hA7, 0, 0, 2));
    vt.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 8'hA7, 1, 0, 2));
    vt.push_back(mk(0, 0, 0, 1, 8'h00, 1, 0, 8'hA7, 2, 0, 2));
    vt.push_back(mk(0, 0, 1, 1, 8'hA8, 1, 1, 8'hA8, 2, 0, 2));
    vt.push_back(mk(0, 1, 1, 1, 8'hEE, 0, 0, 8'hA8, 4, 0, 2));
    vt.push_back(mk(0, 0, 0, 1, 8'h00, 1, 0, 8'hA8, 4, 1, 2));
    vt.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 8'hA8, 4, 1, 2));
    vt.push_back(mk(0, 0, 1, 0, 8'hA9, 1, 1, 8'hA9, 3, 1, 2));
    vt.push_back(mk(1, 0, 1, 1, 8'h55, 0, 0, 8'h00, 4, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 8'hB1, 1, 1, 8'hB1, 3, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 8'hB2, 1, 1, 8'hB2, 2, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 8'hB3, 1, 1, 8'hB3, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 8'hB4, 1, 1, 8'hB4, 0, 0, 0));
    for (int k = 1; k <= 5; k++)
      vt.push_back(mk(0, 0, 1, 0, 8'hC0, 0, 0, 8'hB4, 0, 0, k));
    vt.push_back(mk(0, 1, 1, 0, 8'hC1, 0, 0, 8'hB4, 4, 0, 5));
    vt.push_back(mk(0, 0, 1, 0, 8'hD1, 1, 1, 8'hD1, 3, 0, 5));
    vt.push_back(mk(0, 1, 1, 1, 8'hD2, 0, 0, 8'hD1, 4, 0, 5));

    foreach (vt[i]) apply(vt[i], $sformatf("vec%0d", i));

    // Streaming with a credit returned every cycle keeps credits flat at 2.
    apply(mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 4, 0, 0), "str_rst");
    apply(mk(0, 0, 1, 0, 8'h11, 1, 1, 8'h11, 3, 0, 0), "str_a0");
    apply(mk(0, 0, 1, 0, 8'h12, 1, 1, 8'h12, 2, 0, 0), "str_a1");
    for (int k = 0; k < 6; k++) begin
      logic [DW-1:0] d;
      d = DW'(8'h20 + k);
      apply(mk(0, 0, 1, 1, d, 1, 1, d, 2, 0, 0), $sformatf("str_b%0d", k));
    end
    // Drain back to full credit, then one extra credit is an overflow.
    apply(mk(0, 0, 0, 1, 8'h00, 1, 0, 8'h25, 3, 0, 0), "drn0");
    apply(mk(0, 0, 0, 1, 8'h00, 1, 0, 8'h25, 4, 0, 0), "drn1");
    apply(mk(0, 0, 0, 1, 8'h00, 1, 0, 8'h25, 4, 1, 0), "drn_ovf");
    apply(mk(0, 0, 0, 0, 8'h00, 1, 0, 8'h25, 4, 1, 0), "drn_hold");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_credit_tx.md
Name: fifo_credit_tx

Overview:
Transmit-side partner of the common FIFO: it feeds a remote push/pop FIFO of known DEPTH across a registered link. Flow control is by credits, not by the remote full_o.
- Accepts an upstream valid/ready stream.
- Issues registered push_o/data_o beats.
- Each credit_i pulse is one remote pop returning a slot.
- Mirrors the remote fill state locally as full_o, empty_o, alm_full_o and alm_empty_o.

Parameters:
DATA_WIDTH, 32, payload width when dtype is the default logic vector
DEPTH, 8, remote FIFO depth = initial credit count; must be >= 1
ALM_FULL_TH, 1, alm_full_o when in-flight count >= this; must be <= DEPTH
ALM_EMPTY_TH, 1, alm_empty_o when in-flight count <= this; must be <= DEPTH
dtype, logic [DATA_WIDTH-1:0], payload type
CNT_W, $clog2(DEPTH+1), counter width; derived, do not override

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, synchronous, active-high
flush_i  in  1  discard in-flight accounting, restore full credit
valid_i  in  1  upstream beat valid
ready_o  out  1  upstream beat accepted when valid_i && ready_o
data_i  in  dtype  upstream payload
push_o  out  1  registered push strobe to remote FIFO
data_o  out  dtype  registered payload, valid when push_o=1
credit_i  in  1  one remote slot freed (remote pop), one pulse per slot
full_o  out  1  credits == 0
empty_o  out  1  credits == DEPTH (nothing in flight)
alm_full_o  out  1  (DEPTH - credits) >= ALM_FULL_TH
alm_empty_o  out  1  (DEPTH - credits) <= ALM_EMPTY_TH
credits_o  out  CNT_W  current credit count
err_o  out  1  sticky credit-overflow error
stall_cnt_o  out  32  stall statistics (see Optional Feature)

Behaviour:
- Reset (rst_i=1 at a clock edge) sets these values:
  - credits = DEPTH
  - push_o = 0, data_o = '0
  - err_o = 0, stall_cnt_o = 0
  - Consequently full_o=0, empty_o=1, alm_full_o=(0>=ALM_FULL_TH), alm_empty_o=1.
- Reset mid-operation discards all in-flight accounting; credit_i is ignored in the reset cycle.
- Ready is combinational: ready_o = (credits != 0) && !flush_i && !rst_i. ready_o never depends on valid_i.
- Accept (valid_i && ready_o):
  - next cycle push_o=1 and data_o=data_i; latency is exactly 1 cycle;
  - credits decrement in the same edge.
- No accept: next cycle push_o=0 and data_o holds its last value.
- Back-to-back accepts give push_o=1 on consecutive cycles, limited only by credits.
- Credit update per edge, with acc=accept and cr=credit_i:
  - acc&!cr: credits-1
  - !acc&cr: credits+1
  - acc&cr: unchanged
  - neither: unchanged
- Credit return at zero credits: ready_o stays 0 that cycle (no combinational credit-to-ready path); ready_o rises the next cycle.
- Overflow: credit_i=1 while credits==DEPTH and no accept:
  - credits saturate at DEPTH;
  - err_o is set and stays set until rst_i (flush_i does not clear it).
- Flush (flush_i=1):
  - ready_o=0, so nothing is accepted;
  - next cycle credits=DEPTH and push_o=0;
  - credit_i in the flush cycle is ignored;
  - the remote FIFO is flushed by the system in the same cycle.
- Status flags are combinational decodes of the registered credits; there is no extra latency.
- All arithmetic is in CNT_W bits unsigned. Decrement happens only when credits>0 and increment only when credits<DEPTH, so wrap-around is impossible.
- Elaboration assertions (simulation only, suppressed by COMMON_CELLS_ASSERTS_OFF) check:
  - DEPTH >= 1
  - ALM_FULL_TH <= DEPTH
  - ALM_EMPTY_TH <= DEPTH

Optional Feature:
Macro FIFO_CREDIT_TX_STATS_EN.
- Defined:
  - stall_cnt_o is a 32-bit counter that increments each cycle with valid_i=1 && credits==0 && !flush_i;
  - it saturates at 2^32-1;
  - it clears on rst_i only.
- Undefined: stall_cnt_o is tied to 0 and no counter flops exist.

Test Plan:
- DEPTH=4, reset then valid_i=1 held, no credits -> 4 accepts, push_o=1 on cycles 1..4 with data_o matching data_i, then full_o=1 and ready_o=0; credits_o counts 4,3,2,1,0.
- Credits=0 with valid_i=1, pulse credit_i one cycle -> ready_o=1 the following cycle, one push_o beat, credits_o back to 0.
- Credits=2 with accept and credit_i in the same cycle -> credits_o stays 2 and push_o=1 next cycle.
- Credits=DEPTH=4, credit_i=1 with no accept -> credits_o=4 (saturated) and err_o=1; err_o survives a flush_i pulse and clears only on rst_i.
- Credits=1 in flight, flush_i=1 with valid_i=1 and credit_i=1 -> ready_o=0, next cycle credits_o=4, push_o=0, empty_o=1.
- FIFO_CREDIT_TX_STATS_EN defined, credits=0 with valid_i=1 for 5 cycles -> stall_cnt_o=5; with the macro undefined stall_cnt_o=0.
